imm_packer: RTL and testbench

Pipelined immediate encoder: the inverse of the Decode-stage `SignExtend`. It takes a 32-bit signed immediate value, an `ImmSrc` type, and a base instruction word, and scatters the immediate into the instruction's immediate bit fields. It also flags values that are not representable for that type. It sits in the program loader / self-test path that builds instruction words for the core. Its outputs must round-trip exactly through `SignExtend` when no error is flagged.

---
 rtl/imm_pkg.sv | 25 ++
 rtl/imm_pack_comb.sv | 41 ++++
 rtl/imm_packer.sv | 86 ++++++++
 tb/tb_imm_packer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared ImmSrc code points and helpers for the immediate encode/decode path.
// Used by SignExtend users, the control decoder and imm_packer.
package imm_pkg;

  localparam logic [1:0] IMM_UJ = 2'b00;
  localparam logic [1:0] IMM_I  = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;
  localparam logic [1:0] IMM_S  = 2'b11;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } packWordT;

  // True when v[31:msb] are all equal, i.e. v fits in msb+1 bits as a signed value.
  function automatic logic upperSame(input logic [31:0] v, input int msb);
    logic same;
    same = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= msb && v[i] != v[msb]) same = 1'b0;
    end
    return same;
  endfunction

endpackage

// File: rtl/imm_pack_comb.sv
// Combinational immediate scatter into an instruction word plus range/alignment check.
// Zero latency; no flow control.
module imm_pack_comb
  import imm_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [1:0]  imm_src,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = base;
    err   = 1'b0;
    unique case (imm_src)
      IMM_UJ: begin
        instr[31:12] = imm[19:0];
        err          = !upperSame(imm, 19);
      end
      IMM_I: begin
        instr[31:20] = imm[11:0];
        err          = !upperSame(imm, 11);
      end
      IMM_B: begin
        // Bit 0 is implied zero in branch offsets, so an odd value cannot round-trip.
        instr[31]    = imm[12];
        instr[7]     = imm[11];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        err          = imm[0] || !upperSame(imm, 12);
      end
      IMM_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        err          = !upperSame(imm, 11);
      end
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Two-stage immediate encoder: input accepted in cycle N is presented in N+2.
// Valid/ready both sides; holds two words under backpressure, then drops in_ready.
module imm_packer
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [1:0]       in_imm_src,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      packInstr;
  logic             packErr;
  packWordT         s1Word;
  packWordT         s2Word;
  logic             s1Valid;
  logic             s2Valid;
  logic             s2Load;
  logic             s1Adv;
  logic             inFire;
  logic [CNT_W-1:0] errCount;

  imm_pack_comb uPack (
    .imm     (in_imm),
    .imm_src (in_imm_src),
    .base    (in_base),
    .instr   (packInstr),
    .err     (packErr)
  );

  assign s2Load   = !s2Valid || out_ready;
  assign s1Adv    = s1Valid && s2Load;
  assign in_ready = !s1Valid || s1Adv;
  assign inFire   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Word  <= '0;
    end else if (inFire) begin
      s1Valid      <= 1'b1;
      s1Word.instr <= packInstr;
      s1Word.err   <= packErr;
    end else if (s1Adv) begin
      s1Valid <= 1'b0;
    end
  end

  // Output register only captures new data, so a stalled word holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid <= 1'b0;
      s2Word  <= '0;
    end else if (s2Load) begin
      s2Valid <= s1Valid;
      if (s1Valid) s2Word <= s1Word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCount <= '0;
    end else if (err_clr) begin
      errCount <= '0;
    end else if (s2Valid && out_ready && s2Word.err && !(&errCount)) begin
      errCount <= errCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = s2Valid;
  assign out_instr = s2Word.instr;
  assign out_err   = s2Word.err;
  assign err_count = errCount;

endmodule

// File: tb/tb_imm_packer.sv
// Bench for imm_packer: random and directed words checked against a bit-map model and a decode round trip.
module tb_imm_packer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_imm = '0;
  logic [1:0]    in_imm_src = '0;
  logic [31:0]   in_base = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic          out_err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] err_count;

  imm_packer #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm     (in_imm),
    .in_imm_src (in_imm_src),
    .in_base    (in_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .err_clr    (err_clr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          err;
    logic [31:0] imm;
    logic [1:0]  src;
    int          cyc;
  } expT;

  expT   expQ[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle = 0;
  int    cntModel = 0;
  int    readyMode = 0; // 0 high, 1 low, 2 random
  bit    readyHist[int];
  bit    prevStall = 0;
  logic [31:0] prevInstr;
  logic  prevErr;

  // Which immediate bit lands in instruction bit k, or -1 if k comes from the base word.
  function automatic int immBitFor(input logic [1:0] src, input int k);
    case (src)
      2'b00: return (k >= 12) ? k - 12 : -1;
      2'b01: return (k >= 20) ? k - 20 : -1;
      2'b10: begin
        if (k == 31) return 12;
        if (k == 7) return 11;
        if (k >= 25 && k <= 30) return k - 20;
        if (k >= 8 && k <= 11) return k - 7;
        return -1;
      end
      default: begin
        if (k >= 25) return k - 20;
        if (k >= 7 && k <= 11) return k - 7;
        return -1;
      end
    endcase
  endfunction

  function automatic logic [31:0] modelInstr(input logic [31:0] imm, input logic [1:0] src,
                                             input logic [31:0] base);
    logic [31:0] r;
    int idx;
    for (int k = 0; k < 32; k++) begin
      idx = immBitFor(src, k);
      r[k] = (idx < 0) ? base[k] : imm[idx];
    end
    return r;
  endfunction

  function automatic bit modelErr(input logic [31:0] imm, input logic [1:0] src);
    int v;
    v = $signed(imm);
    case (src)
      2'b00:   return (v < -(1 << 19)) || (v > (1 << 19) - 1);
      2'b10:   return (v < -4096) || (v > 4095) || (imm[0] == 1'b1);
      default: return (v < -2048) || (v > 2047);
    endcase
  endfunction

  // SignExtend as seen by the decoder: gather the field and sign-extend arithmetically.
  function automatic logic [31:0] decode(input logic [31:0] ins, input logic [1:0] src);
    int x;
    case (src)
      2'b00: begin x = int'(ins[31:12]); if (x >= (1 << 19)) x -= (1 << 20); end
      2'b01: begin x = int'(ins[31:20]); if (x >= 2048) x -= 4096; end
      2'b10: begin
        x = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (x >= 4096) x -= 8192;
      end
      default: begin
        x = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (x >= 2048) x -= 4096;
      end
    endcase
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (readyMode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin : cmpProc
    expT e;
    bit  popErr;
    bit  popped;
    cycle++;
    readyHist[cycle] = out_ready;
    if (!rst_n) begin
      expQ.delete();
      cntModel = 0;
      prevStall = 0;
    end else begin
      popErr = 0;
      popped = 0;
      chk("err_count", 32'(err_count), cntModel);
      if (prevStall) begin
        checks++;
        if (!out_valid || out_instr !== prevInstr || out_err !== prevErr) begin
          errors++;
          $display("FAIL stall_hold actual v=%b %h/%b required v=1 %h/%b",
                   out_valid, out_instr, out_err, prevInstr, prevErr);
        end
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual %h required none", out_instr);
        end else begin
          e = expQ.pop_front();
          popped = 1;
          popErr = e.err;
          chk("out_instr", out_instr, e.instr);
          chk("out_err", 32'(out_err), 32'(e.err));
          if (!e.err) chk("round_trip", decode(out_instr, e.src), e.imm);
          if (readyHist.exists(e.cyc + 1) && readyHist[e.cyc + 1] &&
              readyHist.exists(e.cyc + 2) && readyHist[e.cyc + 2])
            chk("latency", cycle - e.cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        e.instr = modelInstr(in_imm, in_imm_src, in_base);
        e.err   = modelErr(in_imm, in_imm_src);
        e.imm   = in_imm;
        e.src   = in_imm_src;
        e.cyc   = cycle;
        expQ.push_back(e);
      end
      if (err_clr) cntModel = 0;
      else if (popped && popErr && cntModel < (1 << CW) - 1) cntModel++;
      prevStall = out_valid && !out_ready;
      prevInstr = out_instr;
      prevErr   = out_err;
    end
  end

  task automatic sendWord(input logic [31:0] imm, input logic [1:0] src, input logic [31:0] base);
    int waitCnt;
    bit done;
    waitCnt = 0;
    done = 0;
    in_valid = 1'b1;
    in_imm = imm;
    in_imm_src = src;
    in_base = base;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      waitCnt++;
      if (!done && waitCnt > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual in_ready=0 required 1");
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic randWord(input bit allowBad, output logic [31:0] imm,
                          output logic [1:0] src, output logic [31:0] base);
    int v;
    src  = 2'($urandom_range(0, 3));
    base = $urandom;
    case (src)
      2'b00: v = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
      2'b10: v = (int'($urandom_range(0, 8191)) - 4096) & ~1;
      default: v = int'($urandom_range(0, 4095)) - 2048;
    endcase
    imm = v;
    if (allowBad && $urandom_range(0, 3) == 0) imm = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual %0d pending required 0", expQ.size());
    end
  endtask

  initial begin
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] base;

    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    chk("model_i_2048", modelInstr(32'd2048, 2'b01, 32'h0), 32'h8000_0000);
    chk("model_i_2048_err", 32'(modelErr(32'd2048, 2'b01)), 1);
    chk("model_i_2047", modelInstr(32'd2047, 2'b01, 32'h0), 32'h7FF0_0000);
    chk("model_b_3", modelInstr(32'd3, 2'b10, 32'h0), 32'h0000_0100);
    chk("model_b_3_err", 32'(modelErr(32'd3, 2'b10)), 1);
    chk("model_b_m4096", modelInstr(-32'sd4096, 2'b10, 32'h0), 32'h8000_0000);
    chk("model_uj_80000_err", 32'(modelErr(32'h80000, 2'b00)), 1);
    chk("model_s_m1", modelInstr(32'hFFFF_FFFF, 2'b11, 32'h0), 32'hFE00_0F80);
    chk("decode_s_m1", decode(32'hFE00_0F80, 2'b11), 32'hFFFF_FFFF);

    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    readyMode = 0;
    for (int i = 0; i < 200; i++) begin
      randWord(0, imm, src, base);
      sendWord(imm, src, base);
    end

    sendWord(-32'sd2048, 2'b01, $urandom);
    sendWord(32'd2047, 2'b01, $urandom);
    sendWord(32'd2048, 2'b01, 32'h0);
    sendWord(-32'sd4096, 2'b10, $urandom);
    sendWord(32'd4094, 2'b10, $urandom);
    sendWord(32'd6, 2'b10, $urandom);
    sendWord(32'd3, 2'b10, $urandom);
    sendWord(32'h7FFFF, 2'b00, $urandom);
    sendWord(32'h80000, 2'b00, $urandom);
    sendWord(-32'sd2048, 2'b11, $urandom);
    sendWord(32'd2048, 2'b11, $urandom);
    drain();

    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      randWord(1, imm, src, base);
      sendWord(imm, src, base);
    end
    readyMode = 0;
    drain();

    // Five words against a four-cycle output stall.
    readyMode = 1;
    @(posedge clk);
    #1;
    sendWord(32'd11, 2'b01, $urandom);
    sendWord(32'd22, 2'b11, $urandom);
    in_valid = 1'b1;
    in_imm = 32'd33;
    in_imm_src = 2'b01;
    in_base = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    readyMode = 0;
    sendWord(32'd33, 2'b01, 32'h1234_5678);
    sendWord(32'd44, 2'b10, $urandom);
    sendWord(32'd55, 2'b00, $urandom);
    drain();

    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) sendWord(32'd5000, 2'b01, $urandom);
    drain();
    @(negedge clk);
    chk("count_3", 32'(err_count), 3);
    @(posedge clk);
    #1;
    sendWord(32'd5000, 2'b11, $urandom);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("count_clr_prio", 32'(err_count), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) sendWord(32'h0010_0000, 2'b00, $urandom);
    drain();
    @(negedge clk);
    chk("count_sat", 32'(err_count), (1 << CW) - 1);
    @(posedge clk);
    #1;

    sendWord(32'd9999, 2'b01, $urandom);
    sendWord(32'd7, 2'b01, $urandom);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_err_count", 32'(err_count), 0);
    chk("rst_mid_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    sendWord(32'd100, 2'b11, 32'hDEAD_BEEF);
    sendWord(-32'sd100, 2'b10, 32'hCAFE_F00D);
    drain();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
